// File: rtl/control_sequencer_if.sv
// -----------------------------------------------------------------------------
// control_sequencer_if
//
// Bundles everything that passes between the control sequencer and the
// datapath it steers.
//
//   Datapath -> sequencer:
//     IR[31:0]    current instruction, opcode in IR[31:27]
//     con_ff      branch condition flag
//     mem_ready   memory handshake, transfer completes in the cycle it is 1
//   Sequencer -> datapath:
//     PCout, Zlowout, MDRout, Cout                  bus drive enables
//     MARin, PCin, MDRin, IRin, Yin, Zin, CONin     register load enables
//     IncPC, Read, Write                            PC increment, memory strobes
//     Gra, Grb, Grc, Rin, Rout, BAout               register select/encode
//     alu_op[4:0]                                   ALU operation code
//     run                                           1 while executing
//     err                                           sticky memory-timeout flag
//
// The master modport is the sequencer side and the slave modport is the
// datapath side.
// -----------------------------------------------------------------------------
interface control_sequencer_if;
    logic [31:0] IR;
    logic        con_ff;
    logic        mem_ready;

    logic        PCout, Zlowout, MDRout, Cout;
    logic        MARin, PCin, MDRin, IRin, Yin, Zin, CONin;
    logic        IncPC, Read, Write;
    logic        Gra, Grb, Grc, Rin, Rout, BAout;
    logic [4:0]  alu_op;
    logic        run;
    logic        err;

    modport master (
        input  IR, con_ff, mem_ready,
        output PCout, Zlowout, MDRout, Cout,
        output MARin, PCin, MDRin, IRin, Yin, Zin, CONin,
        output IncPC, Read, Write,
        output Gra, Grb, Grc, Rin, Rout, BAout,
        output alu_op, run, err
    );

    modport slave (
        output IR, con_ff, mem_ready,
        input  PCout, Zlowout, MDRout, Cout,
        input  MARin, PCin, MDRin, IRin, Yin, Zin, CONin,
        input  IncPC, Read, Write,
        input  Gra, Grb, Grc, Rin, Rout, BAout,
        input  alu_op, run, err
    );
endinterface

// File: rtl/control_sequencer.sv
// -----------------------------------------------------------------------------
// control_sequencer
//
// Moore FSM that walks the datapath through instruction fetch (T0-T2) and the
// per-opcode execute steps (T3-T7). It stalls in the memory wait states until
// mem_ready is seen, and it stops in HALT after a halt instruction or after a
// memory timeout.
//
// Parameters:
//   MEM_TIMEOUT  maximum stalled cycles in any wait state, 0 disables
//   TW           wait counter width, 2**TW must exceed MEM_TIMEOUT
//
// Ports:
//   clock   system clock, all state changes on the rising edge
//   reset   synchronous active-high reset, forces T0 and clears counter/err
//   bus     control_sequencer_if master modport (IR/handshake in, strobes out)
// -----------------------------------------------------------------------------
module control_sequencer #(
    parameter int MEM_TIMEOUT = 0,
    parameter int TW          = 8
) (
    input  logic                   clock,
    input  logic                   reset,
    control_sequencer_if.master    bus
);

    typedef enum logic [3:0] {
        T0, T1, T2, T3, T4, T5, T6, T7, HALT
    } state_t;

    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_LDI  = 5'b00001;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_ADDI = 5'b01100;
    localparam logic [4:0] OP_ANDI = 5'b01101;
    localparam logic [4:0] OP_ORI  = 5'b01110;
    localparam logic [4:0] OP_BR   = 5'b10010;
    localparam logic [4:0] OP_JR   = 5'b10100;
    localparam logic [4:0] OP_HALT = 5'b11011;

    // The timeout fires on the MEM_TIMEOUT-th stalled cycle, i.e. while the
    // counter still shows MEM_TIMEOUT-1 and is about to reach MEM_TIMEOUT.
    localparam logic [TW-1:0] WAIT_LIMIT =
        (MEM_TIMEOUT > 0) ? TW'(MEM_TIMEOUT - 1) : '0;

    state_t        state, state_next;
    logic [TW-1:0] wait_cnt;
    logic          err_q;
    logic [4:0]    opcode;
    logic          is_rtype, is_imm, is_ldi, is_ld, is_st, is_br, is_jr, is_halt;
    logic          waiting, timeout_hit;

    assign opcode   = bus.IR[31:27];
    assign is_rtype = (opcode == OP_ADD) || (opcode == OP_SUB) ||
                      (opcode == OP_AND) || (opcode == OP_OR);
    assign is_imm   = (opcode == OP_ADDI) || (opcode == OP_ANDI) ||
                      (opcode == OP_ORI);
    assign is_ldi   = (opcode == OP_LDI);
    assign is_ld    = (opcode == OP_LD);
    assign is_st    = (opcode == OP_ST);
    assign is_br    = (opcode == OP_BR);
    assign is_jr    = (opcode == OP_JR);
    assign is_halt  = (opcode == OP_HALT);

    // Memory wait states: instruction fetch, ld data read, st data write.
    assign waiting     = (state == T1) || ((state == T6) && is_ld) ||
                         ((state == T7) && is_st);
    assign timeout_hit = (MEM_TIMEOUT > 0) && waiting && !bus.mem_ready &&
                         (wait_cnt == WAIT_LIMIT);

    // State register, wait counter and sticky error flag. The counter
    // restarts on every state change so each wait begins counting from zero,
    // and it saturates rather than wrapping when the timeout is disabled.
    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= T0;
            wait_cnt <= '0;
            err_q    <= 1'b0;
        end else begin
            state <= state_next;
            if (state_next != state) begin
                wait_cnt <= '0;
            end else if (waiting && !bus.mem_ready && (wait_cnt != '1)) begin
                wait_cnt <= wait_cnt + TW'(1);
            end
            if (timeout_hit) begin
                err_q <= 1'b1;
            end
        end
    end

    // Next-state logic: fetch, then a per-opcode path back to T0.
    always_comb begin
        state_next = state;
        case (state)
            T0: state_next = T1;
            T1: begin
                if (bus.mem_ready)  state_next = T2;
                else if (timeout_hit) state_next = HALT;
            end
            T2: state_next = T3;
            T3: begin
                if (is_halt)
                    state_next = HALT;
                else if (is_rtype || is_imm || is_ldi || is_ld || is_st || is_br)
                    state_next = T4;
                else
                    state_next = T0;
            end
            T4: state_next = T5;
            T5: state_next = (is_ld || is_st || is_br) ? T6 : T0;
            T6: begin
                if (is_ld) begin
                    if (bus.mem_ready)    state_next = T7;
                    else if (timeout_hit) state_next = HALT;
                end else if (is_st) begin
                    state_next = T7;
                end else begin
                    state_next = T0;
                end
            end
            T7: begin
                if (is_st) begin
                    if (bus.mem_ready)    state_next = T0;
                    else if (timeout_hit) state_next = HALT;
                end else begin
                    state_next = T0;
                end
            end
            HALT:    state_next = HALT;
            default: state_next = T0;
        endcase
    end

    // Output decode. Everything defaults to 0; reset blanks all outputs
    // combinationally so nothing strobes while reset is held.
    always_comb begin
        bus.PCout   = 1'b0; bus.Zlowout = 1'b0; bus.MDRout = 1'b0; bus.Cout  = 1'b0;
        bus.MARin   = 1'b0; bus.PCin    = 1'b0; bus.MDRin  = 1'b0; bus.IRin  = 1'b0;
        bus.Yin     = 1'b0; bus.Zin     = 1'b0; bus.CONin  = 1'b0;
        bus.IncPC   = 1'b0; bus.Read    = 1'b0; bus.Write  = 1'b0;
        bus.Gra     = 1'b0; bus.Grb     = 1'b0; bus.Grc    = 1'b0;
        bus.Rin     = 1'b0; bus.Rout    = 1'b0; bus.BAout  = 1'b0;
        bus.alu_op  = 5'b00000;
        bus.run     = 1'b0;
        if (!reset) begin
            bus.run = (state != HALT);
            case (state)
                T0: begin
                    bus.PCout = 1'b1; bus.MARin = 1'b1; bus.IncPC = 1'b1; bus.Zin = 1'b1;
                end
                T1: begin
                    bus.Zlowout = 1'b1; bus.PCin = 1'b1; bus.Read = 1'b1; bus.MDRin = 1'b1;
                end
                T2: begin
                    bus.MDRout = 1'b1; bus.IRin = 1'b1;
                end
                T3: begin
                    if (is_rtype || is_imm) begin
                        bus.Grb = 1'b1; bus.Rout = 1'b1; bus.Yin = 1'b1;
                    end else if (is_ldi || is_ld || is_st) begin
                        bus.Grb = 1'b1; bus.BAout = 1'b1; bus.Yin = 1'b1;
                    end else if (is_br) begin
                        bus.Gra = 1'b1; bus.Rout = 1'b1; bus.CONin = 1'b1;
                    end else if (is_jr) begin
                        bus.Gra = 1'b1; bus.Rout = 1'b1; bus.PCin = 1'b1;
                    end
                end
                T4: begin
                    if (is_rtype) begin
                        bus.Grc = 1'b1; bus.Rout = 1'b1; bus.Zin = 1'b1; bus.alu_op = opcode;
                    end else if (is_imm) begin
                        bus.Cout = 1'b1; bus.Zin = 1'b1; bus.alu_op = opcode;
                    end else if (is_ldi || is_ld || is_st) begin
                        bus.Cout = 1'b1; bus.Zin = 1'b1; bus.alu_op = OP_ADD;
                    end else if (is_br) begin
                        bus.PCout = 1'b1; bus.Yin = 1'b1;
                    end
                end
                T5: begin
                    if (is_rtype || is_imm || is_ldi) begin
                        bus.Zlowout = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1;
                    end else if (is_ld || is_st) begin
                        bus.Zlowout = 1'b1; bus.MARin = 1'b1;
                    end else if (is_br) begin
                        bus.Cout = 1'b1; bus.Zin = 1'b1; bus.alu_op = OP_ADD;
                    end
                end
                T6: begin
                    if (is_ld) begin
                        bus.Read = 1'b1; bus.MDRin = 1'b1;
                    end else if (is_st) begin
                        bus.Gra = 1'b1; bus.Rout = 1'b1; bus.MDRin = 1'b1;
                    end else if (is_br) begin
                        // Branch target is always driven; it only loads when taken.
                        bus.Zlowout = 1'b1; bus.PCin = bus.con_ff;
                    end
                end
                T7: begin
                    if (is_ld) begin
                        bus.MDRout = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1;
                    end else if (is_st) begin
                        bus.Write = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.err = err_q && !reset;

endmodule
